buffered_bridge_tx: RTL and testbench



---
 rtl/buffered_bridge_tx.sv | 120 ++++++++++++
 tb/tb_buffered_bridge_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/buffered_bridge_tx.sv
// Queues read responses from a core's output bus and serializes each one as
// an ASCII frame "M" + 4 hex digits + CR LF toward a byte-wide UART transmitter.
module buffered_bridge_tx #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [15:0]              rdata_i,
  input  logic                     rw_i,
  input  logic                     valid_i,
  output logic [7:0]               data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [2:0]    LAST_IDX   = 3'd6;

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state, state_next;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [15:0]     frame_buf;
  logic [2:0]      idx, idx_next;

  logic push_req, not_empty, full, xfer, last_xfer, pop, push_ok, drop;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign push_req  = valid_i && !rw_i;
  assign not_empty = (level_o != '0);
  assign full      = (level_o == FULL_LEVEL);
  assign xfer      = valid_o && ready_i;
  assign last_xfer = xfer && (idx == LAST_IDX);
  // A pop happens when IDLE picks up work or when the LF of the current frame
  // leaves with more queued, so consecutive frames run with no idle cycle.
  assign pop       = not_empty && ((state == IDLE) || last_xfer);
  assign push_ok   = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;

  // State register plus FIFO bookkeeping.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      frame_buf  <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level_o    <= '0;
      overflow_o <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (pop) begin
        frame_buf <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
      end
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (push_ok && !pop)      level_o <= level_o + 1'b1;
      else if (pop && !push_ok) level_o <= level_o - 1'b1;
      if (drop) overflow_o <= 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and level
  // define which entries are live, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) mem[wr_ptr] <= rdata_i;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch forms.
    state_next = state;
    idx_next   = idx;
    unique case (state)
      IDLE: begin
        if (not_empty) begin
          state_next = SEND;
          idx_next   = '0;
        end
      end
      SEND: begin
        if (xfer) begin
          if (idx == LAST_IDX) begin
            idx_next = '0;
            if (!not_empty) state_next = IDLE;
          end else begin
            idx_next = idx + 3'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode only registered state, so data_o never depends on ready_i.
  always_comb begin
    valid_o = (state == SEND);
    unique case (idx)
      3'd1:    data_o = hex_ascii(frame_buf[15:12]);
      3'd2:    data_o = hex_ascii(frame_buf[11:8]);
      3'd3:    data_o = hex_ascii(frame_buf[7:4]);
      3'd4:    data_o = hex_ascii(frame_buf[3:0]);
      3'd5:    data_o = 8'h0D;
      3'd6:    data_o = 8'h0A;
      default: data_o = 8'h4D;
    endcase
  end

endmodule

// File: tb/tb_buffered_bridge_tx.sv
// Directed bench for buffered_bridge_tx: frame format, latency, write filtering,
// overflow, full-with-pop, random backpressure and reset mid-frame.
module tb_buffered_bridge_tx;

  localparam int DEPTH = 8;
  localparam logic [8*16-1:0] HEXS = "0123456789ABCDEF";

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] rdata_i;
  logic        rw_i, valid_i, ready_i;
  logic [7:0]  data_o;
  logic        valid_o, overflow_o;
  logic [$clog2(DEPTH):0] level_o;

  int checks = 0;
  int failures = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic [7:0] prev_data;
  logic       hold;

  buffered_bridge_tx #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rdata_i(rdata_i), .rw_i(rw_i), .valid_i(valid_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .level_o(level_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, expv, $time);
    end
  endtask

  // Byte collector and hold-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold <= 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", {31'b0, valid_o}, 32'd1);
        check("hold_data", {24'b0, data_o}, {24'b0, prev_data});
      end
      if (valid_o && ready_i) got.push_back(data_o);
      hold      <= valid_o && !ready_i;
      prev_data <= data_o;
    end
  end

  function automatic logic [7:0] hexchar(input logic [3:0] n);
    return HEXS[8*(15-int'(n)) +: 8];
  endfunction

  task automatic add_frame(input logic [15:0] v);
    exp_q.push_back(8'h4D);
    for (int k = 3; k >= 0; k--) exp_q.push_back(hexchar(v[4*k +: 4]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_nbytes"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check({tag, "_byte"}, {24'b0, got[i]}, {24'b0, exp_q[i]});
    got.delete();
    exp_q.delete();
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [15:0] d);
    valid_i = v;
    rw_i    = rw;
    rdata_i = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    next();
    rst_n = 1'b1;
    got.delete();
    exp_q.delete();
  endtask

  logic [7:0] single_exp [7];

  initial begin
    drive(1'b0, 1'b0, 16'h0);
    ready_i = 1'b0;
    rst_n   = 1'b0;
    next();
    next();
    check("rst_valid", {31'b0, valid_o}, 32'd0);
    check("rst_level", level_o, 32'd0);
    check("rst_overflow", {31'b0, overflow_o}, 32'd0);
    check("rst_data", {24'b0, data_o}, 32'h4D);
    rst_n = 1'b1;

    // Single read, latency 2 cycles, 7 consecutive bytes.
    single_exp = '{8'h4D, 8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A};
    ready_i = 1'b1;
    drive(1'b1, 1'b0, 16'h1A2F);
    next();
    drive(1'b0, 1'b0, 16'h0);
    check("single_level1", level_o, 32'd1);
    check("single_valid_lat1", {31'b0, valid_o}, 32'd0);
    for (int i = 0; i < 7; i++) begin
      next();
      check("single_valid", {31'b0, valid_o}, 32'd1);
      check("single_byte", {24'b0, data_o}, {24'b0, single_exp[i]});
    end
    next();
    check("single_end_valid", {31'b0, valid_o}, 32'd0);
    got.delete();

    // Write responses never push.
    drive(1'b1, 1'b1, 16'hBEEF);
    next();
    drive(1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      check("wr_level", level_o, 32'd0);
      check("wr_valid", {31'b0, valid_o}, 32'd0);
      next();
    end
    check("wr_overflow", {31'b0, overflow_o}, 32'd0);

    // Burst overflow with the transmitter stalled.
    do_reset();
    ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 16'(i));
      next();
    end
    drive(1'b0, 1'b0, 16'h0);
    check("ovf_level", level_o, 32'd8);
    check("ovf_flag", {31'b0, overflow_o}, 32'd1);
    check("ovf_valid", {31'b0, valid_o}, 32'd1);
    check("ovf_data", {24'b0, data_o}, 32'h4D);
    for (int i = 0; i < 9; i++) add_frame(16'(i));
    ready_i = 1'b1;
    for (int j = 1; j < 63; j++) begin
      next();
      check("ovf_nogap", {31'b0, valid_o}, 32'd1);
    end
    next();
    check("ovf_done_valid", {31'b0, valid_o}, 32'd0);
    check("ovf_done_level", level_o, 32'd0);
    check("ovf_sticky", {31'b0, overflow_o}, 32'd1);
    compare_stream("ovf");

    // Full FIFO, push coincides with the LF transfer that pops.
    do_reset();
    ready_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b0, 16'hA000 + 16'(i));
      add_frame(16'hA000 + 16'(i));
      next();
    end
    drive(1'b0, 1'b0, 16'h0);
    check("fp_level_full", level_o, 32'd8);
    check("fp_no_ovf", {31'b0, overflow_o}, 32'd0);
    ready_i = 1'b1;
    for (int j = 0; j < 6; j++) next();
    check("fp_pre_data", {24'b0, data_o}, 32'h0A);
    drive(1'b1, 1'b0, 16'hA009);
    add_frame(16'hA009);
    next();
    drive(1'b0, 1'b0, 16'h0);
    check("fp_level_stays", level_o, 32'd8);
    check("fp_ovf_stays", {31'b0, overflow_o}, 32'd0);
    check("fp_next_valid", {31'b0, valid_o}, 32'd1);
    check("fp_next_data", {24'b0, data_o}, 32'h4D);
    for (int j = 0; j < 70; j++) next();
    check("fp_done_valid", {31'b0, valid_o}, 32'd0);
    compare_stream("fp");

    // Random backpressure.
    do_reset();
    for (int f = 0; f < 20; f++) begin
      logic [15:0] d;
      d = 16'($urandom);
      drive(1'b1, 1'b0, d);
      add_frame(d);
      for (int c = 0; c < 12; c++) begin
        ready_i = ($urandom_range(0, 3) != 0);
        next();
        drive(1'b0, 1'b0, 16'h0);
      end
    end
    ready_i = 1'b1;
    for (int j = 0; j < 120; j++) next();
    check("rnd_level", level_o, 32'd0);
    check("rnd_valid", {31'b0, valid_o}, 32'd0);
    check("rnd_ovf", {31'b0, overflow_o}, 32'd0);
    compare_stream("rnd");

    // Reset in the middle of a frame with entries queued.
    do_reset();
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 16'h3C5E + 16'(i));
      next();
    end
    drive(1'b0, 1'b0, 16'h0);
    next();
    check("mid_data_idx3", {24'b0, data_o}, 32'h35);
    check("mid_level", level_o, 32'd3);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 16'hFFFF);
    next();
    drive(1'b0, 1'b0, 16'h0);
    check("mid_rst_valid", {31'b0, valid_o}, 32'd0);
    check("mid_rst_level", level_o, 32'd0);
    check("mid_rst_ovf", {31'b0, overflow_o}, 32'd0);
    check("mid_rst_data", {24'b0, data_o}, 32'h4D);
    rst_n = 1'b1;
    got.delete();
    exp_q.delete();
    next();
    check("mid_rst_push_ignored", level_o, 32'd0);
    drive(1'b1, 1'b0, 16'h9D04);
    add_frame(16'h9D04);
    next();
    drive(1'b0, 1'b0, 16'h0);
    for (int j = 0; j < 12; j++) next();
    check("mid_after_valid", {31'b0, valid_o}, 32'd0);
    compare_stream("mid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
